// File: rtl/im_pkg.sv
// Shared types and defaults for the instruction-memory fetch/loader block.
// Holds the FSM state type and the default IM geometry.
package im_pkg;

  localparam int IM_DATA_SIZE    = 32;
  localparam int IM_ADDRESS_SIZE = 10;
  localparam int IM_START        = 'h80;

  typedef enum logic {
    LOAD  = 1'b0,
    FETCH = 1'b1
  } im_state_e;

endpackage

// File: rtl/im_load_cksum.sv
// Running modulo-2^data_size sum of words accepted by the loader.
// Cleared by reset; only advances while add_en is high.
module im_load_cksum
  import im_pkg::*;
#(
  parameter int data_size = IM_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 add_en,
  input  logic [data_size-1:0] add_data,
  output logic [data_size-1:0] sum
);

  logic [data_size-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (add_en) sum_d = sum_q + add_data;
  end

  always_ff @(posedge clk) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/im_fetch_loader.sv
// IM initiator: boots the IM from a load stream, then fetches sequentially.
// Define IM_LOADER_CKSUM_EN to build the load_cksum accumulator.
module im_fetch_loader
  import im_pkg::*;
#(
  parameter int                    data_size    = IM_DATA_SIZE,
  parameter int                    address_size = IM_ADDRESS_SIZE,
  parameter logic [address_size-1:0] im_start   = address_size'(IM_START)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [data_size-1:0]    load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  output logic                    loaded,
  output logic [data_size-1:0]    load_cksum,
  input  logic                    fetch_stall,
  input  logic                    branch_valid,
  input  logic [address_size-1:0] branch_target,
  input  logic [data_size-1:0]    im_instruction,
  output logic [address_size-1:0] IM_address,
  output logic                    IM_read,
  output logic                    IM_write,
  output logic                    IM_enable,
  output logic [data_size-1:0]    IMin,
  output logic [data_size-1:0]    inst,
  output logic [address_size-1:0] inst_pc,
  output logic                    inst_valid
);

  im_state_e state_q, state_d;
  logic [address_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_size-1:0] pc_q, pc_d;
  logic [address_size-1:0] inst_pc_q, inst_pc_d;
  logic inst_valid_q, inst_valid_d;
  logic live_q, live_d;
  logic accept;
  logic ptr_full;

  // live_q keeps the loader quiet for the first cycle after reset
  assign load_ready = live_q && (state_q == LOAD);
  assign loaded     = (state_q == FETCH);
  assign accept     = load_valid && load_ready;
  assign ptr_full   = (wr_ptr_q == '1);
  assign inst       = im_instruction;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    live_d       = 1'b1;
    IM_address   = '0;
    IM_read      = 1'b0;
    IM_write     = 1'b0;
    IM_enable    = 1'b0;
    IMin         = '0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          IM_enable  = 1'b1;
          IM_write   = 1'b1;
          IM_address = wr_ptr_q;
          IMin       = load_data;
          if (!ptr_full) wr_ptr_d = wr_ptr_q + address_size'(1);
          if (load_last || ptr_full) state_d = FETCH;
        end
      end
      FETCH: begin
        IM_read    = 1'b1;
        IM_address = pc_q;
        IM_enable  = !fetch_stall || branch_valid;
        // a branch squashes the wrong-path read issued this cycle
        if (branch_valid) begin
          pc_d         = branch_target;
          inst_valid_d = 1'b0;
        end else if (!fetch_stall) begin
          inst_pc_d    = pc_q;
          pc_d         = pc_q + address_size'(1);
          inst_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      wr_ptr_q     <= im_start;
      pc_q         <= im_start;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      live_q       <= live_d;
    end
  end

`ifdef IM_LOADER_CKSUM_EN
  im_load_cksum #(
    .data_size (data_size)
  ) u_cksum (
    .clk      (clk),
    .rst      (rst),
    .add_en   (accept),
    .add_data (load_data),
    .sum      (load_cksum)
  );
`else
  assign load_cksum = '0;
`endif

endmodule

// File: tb/tb_im_fetch_loader.sv
// Scoreboard bench for im_fetch_loader with behavioural IM and fetch model.
// Two instances: default start address and one near the top of the IM.
module tb_im_fetch_loader;

  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int IM_A = 'h80;
  localparam int IM_B = 'h3FE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_load_valid = 0, a_load_last = 0;
  logic [DW-1:0] a_load_data = '0;
  logic          a_stall = 0, a_br = 0;
  logic [AW-1:0] a_tgt = '0;
  logic          a_load_ready, a_loaded, a_rd, a_wr, a_en, a_inst_valid;
  logic [DW-1:0] a_cksum, a_imin, a_inst, a_im_inst;
  logic [AW-1:0] a_addr, a_inst_pc;

  logic          b_load_valid = 0, b_load_last = 0;
  logic [DW-1:0] b_load_data = '0;
  logic          b_stall = 0, b_br = 0;
  logic [AW-1:0] b_tgt = '0;
  logic          b_load_ready, b_loaded, b_rd, b_wr, b_en, b_inst_valid;
  logic [DW-1:0] b_cksum, b_imin, b_inst, b_im_inst;
  logic [AW-1:0] b_addr, b_inst_pc;

  im_fetch_loader #(.data_size(DW), .address_size(AW), .im_start(10'h080)) dut_a (
    .clk(clk), .rst(rst),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_last(a_load_last),
    .load_ready(a_load_ready), .loaded(a_loaded), .load_cksum(a_cksum),
    .fetch_stall(a_stall), .branch_valid(a_br), .branch_target(a_tgt),
    .im_instruction(a_im_inst), .IM_address(a_addr), .IM_read(a_rd),
    .IM_write(a_wr), .IM_enable(a_en), .IMin(a_imin),
    .inst(a_inst), .inst_pc(a_inst_pc), .inst_valid(a_inst_valid)
  );

  im_fetch_loader #(.data_size(DW), .address_size(AW), .im_start(10'h3FE)) dut_b (
    .clk(clk), .rst(rst),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_last(b_load_last),
    .load_ready(b_load_ready), .loaded(b_loaded), .load_cksum(b_cksum),
    .fetch_stall(b_stall), .branch_valid(b_br), .branch_target(b_tgt),
    .im_instruction(b_im_inst), .IM_address(b_addr), .IM_read(b_rd),
    .IM_write(b_wr), .IM_enable(b_en), .IMin(b_imin),
    .inst(b_inst), .inst_pc(b_inst_pc), .inst_valid(b_inst_valid)
  );

  // Behavioural instruction memories, cleared by the shared reset
  logic [DW-1:0] mem_a [0:1023];
  logic [DW-1:0] mem_b [0:1023];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_a[i] <= '0;
      a_im_inst <= '0;
    end else if (a_en) begin
      if (a_wr)      mem_a[a_addr] <= a_imin;
      else if (a_rd) a_im_inst <= mem_a[a_addr];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_b[i] <= '0;
      b_im_inst <= '0;
    end else if (b_en) begin
      if (b_wr)      mem_b[b_addr] <= b_imin;
      else if (b_rd) b_im_inst <= mem_b[b_addr];
    end
  end

  typedef struct {
    int            due;
    bit            v;
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: program image plus what the core should currently see
  logic [DW-1:0] ref_mem [0:1023];
  bit            m_v;
  logic [AW-1:0] m_pc, m_opc;
  logic [DW-1:0] m_oins;
  logic [DW-1:0] exp_ck;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs();
    chk("rst_a_ctl", 64'({a_load_ready, a_loaded, a_en, a_wr, a_rd, a_inst_valid}), 64'(0));
    chk("rst_a_dat", 64'({a_cksum, a_imin}), 64'(0));
    chk("rst_a_adr", 64'({a_addr, a_inst_pc}), 64'(0));
    chk("rst_b_ctl", 64'({b_load_ready, b_loaded, b_en, b_wr, b_rd, b_inst_valid}), 64'(0));
    chk("rst_b_dat", 64'({b_cksum, b_imin, b_addr, b_inst_pc}), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    a_load_valid = 0; a_load_last = 0; a_stall = 0; a_br = 0;
    b_load_valid = 0; b_load_last = 0; b_stall = 0; b_br = 0;
    sbq.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_zero_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_held_low", 64'(a_load_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_after_rst", 64'({a_load_ready, b_load_ready}), 64'(2'b11));
    @(posedge clk); #1;
  endtask

  task automatic load_a(input int n, input bit rnd);
    logic [DW-1:0] w;
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : DW'(i + 1) * 32'h11111111;
      a_load_valid = 1'b1;
      a_load_data  = w;
      a_load_last  = (i == n - 1);
      ref_mem[AW'(IM_A + i)] = w;
      sum = sum + w;
      @(negedge clk);
      chk("ld_ctl", 64'({a_en, a_wr, a_rd, a_loaded}), 64'(4'b1100));
      chk("ld_addr", 64'(a_addr), 64'(IM_A + i));
      chk("ld_data", 64'(a_imin), 64'(w));
      @(posedge clk); #1;
    end
    a_load_valid = 1'b0;
    a_load_last  = 1'b0;
`ifdef IM_LOADER_CKSUM_EN
    exp_ck = sum;
`else
    exp_ck = '0;
`endif
    m_pc = AW'(IM_A);
    m_v  = 1'b0;
  endtask

  task automatic fetch_cycle(input bit st, input bit br, input logic [AW-1:0] tg);
    a_stall = st;
    a_br    = br;
    a_tgt   = tg;
    a_load_valid = ($urandom_range(0, 3) == 0);
    if (br) begin
      m_v  = 1'b0;
      m_pc = tg;
    end else if (!st) begin
      m_v    = 1'b1;
      m_opc  = m_pc;
      m_oins = ref_mem[m_pc];
      m_pc   = m_pc + AW'(1);
    end
    sbq.push_back('{cyc + 1, m_v, m_opc, m_oins});
    @(negedge clk);
    chk("im_enable", 64'(a_en), 64'(!st || br));
    chk("fetch_mode", 64'({a_loaded, a_load_ready, a_wr, a_rd}), 64'(4'b1001));
    chk("cksum", 64'(a_cksum), 64'(exp_ck));
    @(posedge clk); #1;
  endtask

  task automatic test_b();
    logic [DW-1:0] w0, w1, w2;
    w0 = DW'($urandom); w1 = DW'($urandom); w2 = DW'($urandom);
    b_stall = 0;
    b_load_valid = 1; b_load_data = w0; b_load_last = 0;
    @(negedge clk);
    chk("b_wr0", 64'({b_en, b_wr, b_rd, b_addr}), 64'({3'b110, 10'h3FE}));
    chk("b_din0", 64'(b_imin), 64'(w0));
    @(posedge clk); #1;
    b_load_data = w1;
    @(negedge clk);
    chk("b_wr1", 64'({b_en, b_wr, b_rd, b_addr}), 64'({3'b110, 10'h3FF}));
    @(posedge clk); #1;
    b_load_data = w2;
    @(negedge clk);
    chk("b_ovf_stop", 64'({b_load_ready, b_wr, b_loaded, b_rd}), 64'(4'b0011));
    chk("b_rd_addr", 64'({b_inst_valid, b_addr}), 64'({1'b0, 10'h3FE}));
    @(posedge clk); #1;
    b_load_valid = 0;
    @(negedge clk);
    chk("b_first", 64'({b_inst_valid, b_inst_pc, b_inst}), 64'({1'b1, 10'h3FE, w0}));
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_second", 64'({b_inst_valid, b_inst_pc, b_inst}), 64'({1'b1, 10'h3FF, w1}));
`ifdef IM_LOADER_CKSUM_EN
    chk("b_cksum", 64'(b_cksum), 64'(w0 + w1));
`else
    chk("b_cksum", 64'(b_cksum), 64'(0));
`endif
    @(posedge clk); #1;
  endtask

  bit st_t[8] = '{0, 0, 1, 1, 0, 1, 0, 0};
  bit br_t[8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  initial begin
    exp_t e;
    int   len;

    fork
      forever begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          chk("inst_valid", 64'(a_inst_valid), 64'(e.v));
          if (e.v) begin
            chk("inst_pc", 64'(a_inst_pc), 64'(e.pc));
            chk("inst", 64'(a_inst), 64'(e.ins));
          end
        end
      end
    join_none

    do_reset();

    load_a(3, 1'b0);
    for (int i = 0; i < 8; i++) fetch_cycle(st_t[i], br_t[i], AW'(IM_A));
    a_stall = 1'b1;
    a_br = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    test_b();

    do_reset();

    len = $urandom_range(8, 24);
    load_a(len, 1'b1);
    for (int i = 0; i < 400; i++)
      fetch_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  AW'(IM_A + $urandom_range(0, len + 1)));

    a_stall = 1'b1;
    a_br = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/im_fetch_loader.md
# im_fetch_loader

Initiator side of the instruction-memory port. After reset it boots the IM by accepting a stream of instruction words over a valid/ready handshake and writing them from `im_start` upward. It then switches to fetch mode and issues sequential reads through the same IM port. It presents each returned instruction with its PC to the core, supporting stall and branch redirect. It sits between the external loader/testbench stream, the IM, and the core's IF stage.

## Interface
- `data_size`, 32, instruction word width
- `address_size`, 10, IM word-address width
- `im_start`, 'h80, first load address and fetch reset PC

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `load_valid`  in  1  load word offered
- `load_data`  in  data_size  word to write
- `load_last`  in  1  marks final word of the program
- `load_ready`  out  1  loader accepting words
- `loaded`  out  1  load phase complete, fetching
- `load_cksum`  out  data_size  running sum of loaded words
- `fetch_stall`  in  1  core cannot take a new instruction
- `branch_valid`  in  1  redirect request
- `branch_target`  in  address_size  redirect PC
- `im_instruction`  in  data_size  IM `instruction` output
- `IM_address`  out  address_size  IM address
- `IM_read`, `IM_write`, `IM_enable`  out  1 each  IM controls
- `IMin`  out  data_size  IM write data
- `inst`  out  data_size  fetched instruction
- `inst_pc`  out  address_size  PC of `inst`
- `inst_valid`  out  1  `inst`/`inst_pc` valid

## Operation
- FSM states:
  - LOAD (reset state)
  - FETCH
- Reset values (cycle after `rst`=1): state LOAD, `wr_ptr`=`pc`=`im_start`. All outputs are 0: `load_ready`, `loaded`, `load_cksum`, `IM_*`, `IMin`, `inst_pc`, `inst_valid`.
- `rst` mid-operation aborts either phase. The IM clears itself on the same reset, so the program must be reloaded.
- LOAD:
  - `load_ready`=1 and `IM_read`=0.
  - On accept (`load_valid`&`load_ready`): `IM_enable`=`IM_write`=1, `IM_address`=`wr_ptr`, `IMin`=`load_data`. All are combinational, so the IM captures the word on the same edge.
  - On accept, `wr_ptr` increments.
  - Go to FETCH after accepting a word with `load_last`=1, or after accepting at `wr_ptr`=2^address_size-1 (overflow is forced last, no wrap).
  - `fetch_stall`/`branch_valid` are ignored.
- FETCH:
  - `loaded`=1, `load_ready`=0, `IM_write`=0, `IM_read`=1, `IM_address`=`pc`.
  - `load_valid` is ignored.
  - `IM_enable` = ~`fetch_stall` | `branch_valid`.
  - Enabled edge, no branch: `inst_pc`<=`pc`, `pc`<=`pc`+1 (mod 2^address_size), `inst_valid`<=1.
  - Edge with `branch_valid`: `pc`<=`branch_target`, `inst_valid`<=0 (squashes the wrong-path read issued this cycle). Branch beats stall.
  - Stall without branch: IM disabled, so the IM holds `instruction`. `pc`, `inst_pc` and `inst_valid` all hold.
- `inst` = `im_instruction` (passthrough).

## Timing
- Load write latency 0: the word is in the IM at the accepting edge. One word per cycle maximum.
- Last accept at edge N: `loaded`=1 and the first read is issued in cycle N+1. First `inst_valid`=1 in cycle N+2 with `inst_pc`=`im_start`.
- Steady fetch: one instruction per cycle, read-to-present latency 1 cycle.
- Branch at edge B: `inst_valid`=0 in cycle B+1, target instruction valid in cycle B+2.

## Configuration
- `IM_LOADER_CKSUM_EN` defined: `load_cksum` accumulates the sum of accepted `load_data`, mod 2^data_size. It is cleared by `rst` and frozen in FETCH.
- Not defined: `load_cksum` is tied to 0 and no adder is built.

## Structure
- Shared package `im_pkg`:
  - FSM state enum `{LOAD, FETCH}`
  - default `data_size`, `address_size`, `im_start`
- One natural sub-module: `im_load_cksum` (the accumulator), instantiated only under `IM_LOADER_CKSUM_EN`.

## Test plan
- Reset, then load 0x11111111, 0x22222222, 0x33333333 with `load_last` on the third -> IM writes at 0x80/0x81/0x82 on consecutive edges, `loaded`=1 next cycle, `load_cksum`=0x66666666 (0 without macro).
- Fetch with no stall after that load -> `inst_valid` rises 2 cycles after the last accept; (`inst_pc`,`inst`) = (0x80,0x11111111), (0x81,0x22222222), (0x82,0x33333333) on consecutive cycles.
- `fetch_stall`=1 for 2 cycles while presenting 0x81 -> `IM_enable`=0 and `inst`/`inst_pc` held at 0x22222222/0x81; resumes with 0x82.
- `branch_valid`=1, `branch_target`=0x80 with `fetch_stall`=1 while presenting 0x82 -> next cycle `inst_valid`=0, following cycle (0x80,0x11111111).
- `im_start`='h3FE, load 3 words without `load_last` -> only 0x3FE and 0x3FF written, FETCH entered after the second, third word not accepted.
- Assert `rst` mid-fetch -> all outputs 0 the next cycle; `load_ready`=1 the cycle after `rst` drops.
